// File: rtl/pending_encoder_if.sv
// Handshake bundle for pending_encoder: event pulses in, encoded index stream out.
// The mask signal exists only when PENDING_ENCODER_MASK_EN is defined.
interface pending_encoder_if #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1
);
  logic [INPUT_WIDTH-1:0]  req;
  logic                    out_ready;
  logic                    out_valid;
  logic [OUTPUT_WIDTH-1:0] out_idx;
  logic [INPUT_WIDTH-1:0]  out_onehot;
  logic [INPUT_WIDTH-1:0]  pending;
  logic                    any;
`ifdef PENDING_ENCODER_MASK_EN
  logic [INPUT_WIDTH-1:0]  mask;

  // master = the encoder producing the index stream; slave = sources plus consumer
  modport master (input req, out_ready, mask,
                  output out_valid, out_idx, out_onehot, pending, any);
  modport slave  (output req, out_ready, mask,
                  input out_valid, out_idx, out_onehot, pending, any);
`else
  modport master (input req, out_ready,
                  output out_valid, out_idx, out_onehot, pending, any);
  modport slave  (output req, out_ready,
                  input out_valid, out_idx, out_onehot, pending, any);
`endif
endinterface

// File: rtl/pending_encoder.sv
// Registered pending-event encoder: latches req pulses, presents one index per handshake,
// fixed lowest-index or round-robin priority. Optional eligibility mask: PENDING_ENCODER_MASK_EN.
module pending_encoder #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1,
  parameter bit ROUND_ROBIN  = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  pending_encoder_if.master  bus
);

  logic                    hs;
  logic [INPUT_WIDTH-1:0]  hs_onehot;
  logic [INPUT_WIDTH-1:0]  p_q;
  logic [INPUT_WIDTH-1:0]  p_next;
  logic [INPUT_WIDTH-1:0]  cand;
  logic [OUTPUT_WIDTH-1:0] ptr_q;
  logic [OUTPUT_WIDTH-1:0] ptr_eff;
  logic [OUTPUT_WIDTH-1:0] sel_idx;
  logic [INPUT_WIDTH-1:0]  sel_onehot;
  logic                    valid_q;
  logic [OUTPUT_WIDTH-1:0] idx_q;
  logic [INPUT_WIDTH-1:0]  onehot_q;
  logic                    any_q;

  assign hs        = valid_q & bus.out_ready;
  assign hs_onehot = hs ? onehot_q : '0;
  // A request landing on the bit being served wins, so the event is kept for later.
  assign p_next    = (p_q & ~hs_onehot) | bus.req;

`ifdef PENDING_ENCODER_MASK_EN
  assign cand = p_q & ~hs_onehot & bus.mask;
`else
  assign cand = p_q & ~hs_onehot;
`endif

  // The index being accepted this edge counts as the last one served.
  assign ptr_eff = hs ? idx_q : ptr_q;

  // Rank each candidate by its wrapped distance from the search start; lowest rank wins.
  // Working in ranks keeps every index below INPUT_WIDTH for non-power-of-two widths.
  always_comb begin
    int start;
    int rank;
    int best;
    // NOTE: every variable gets a default before any conditional write, otherwise latches are inferred.
    sel_idx    = '0;
    sel_onehot = '0;
    start      = 0;
    rank       = 0;
    best       = INPUT_WIDTH;
    if (ROUND_ROBIN)
      start = (int'(ptr_eff) >= INPUT_WIDTH - 1) ? 0 : int'(ptr_eff) + 1;
    for (int j = 0; j < INPUT_WIDTH; j++) begin
      rank = (j >= start) ? (j - start) : (j - start + INPUT_WIDTH);
      if (cand[j] && (rank < best)) begin
        best          = rank;
        sel_idx       = OUTPUT_WIDTH'(j);
        sel_onehot    = '0;
        sel_onehot[j] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q      <= '0;
      ptr_q    <= OUTPUT_WIDTH'(INPUT_WIDTH - 1);
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      any_q    <= 1'b0;
    end else begin
      p_q   <= p_next;
      any_q <= |p_next;
      if (hs)
        ptr_q <= idx_q;
      // A stalled presentation holds; new events and mask changes wait for the next load.
      if (!valid_q || hs) begin
        valid_q  <= |cand;
        idx_q    <= sel_idx;
        onehot_q <= sel_onehot;
      end
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;
  assign bus.pending    = p_q;
  assign bus.any        = any_q;

endmodule

// File: tb/tb_pending_encoder.sv
// Checks a 16-wide fixed-priority and a 5-wide round-robin pending_encoder against a
// cycle-level model built from the pending/candidate/selection rules, plus directed scenarios.
module tb_pending_encoder;

  localparam int WF = 16;
  localparam int WR = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [WF-1:0] req_f  = '0;
  logic          rdy_f  = 1'b0;
  logic [WF-1:0] mask_f = '1;
  logic [WR-1:0] req_r  = '0;
  logic          rdy_r  = 1'b0;

  pending_encoder_if #(.INPUT_WIDTH(WF)) if_fix ();
  pending_encoder_if #(.INPUT_WIDTH(WR)) if_rr ();

  assign if_fix.req       = req_f;
  assign if_fix.out_ready = rdy_f;
  assign if_rr.req        = req_r;
  assign if_rr.out_ready  = rdy_r;
`ifdef PENDING_ENCODER_MASK_EN
  assign if_fix.mask = mask_f;
  assign if_rr.mask  = '1;
`endif

  pending_encoder #(.INPUT_WIDTH(WF), .ROUND_ROBIN(1'b0)) u_fix (
    .clk(clk), .rst_n(rst_n), .bus(if_fix));
  pending_encoder #(.INPUT_WIDTH(WR), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(if_rr));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending set, presented event, last served index.
  typedef struct {
    bit [15:0] pend;
    bit        valid;
    int        idx;
    int        last;
    int        w;
    bit        rr;
  } model_t;

  model_t mf, mr;

  function automatic model_t model_reset(input int w, input bit rr);
    model_t m;
    m.pend = '0; m.valid = 1'b0; m.idx = 0; m.last = w - 1; m.w = w; m.rr = rr;
    return m;
  endfunction

  function automatic model_t step(input model_t m, input bit [15:0] req, input bit ready,
                                 input bit [15:0] msk);
    model_t n = m;
    bit taken = m.valid && ready;
    if (taken) begin
      n.pend[m.idx] = 1'b0;
      n.last = m.idx;
    end
    if (!m.valid || taken) begin
      n.valid = 1'b0;
      n.idx = 0;
      // Walk indices in priority order and take the first eligible one.
      for (int k = 1; k <= m.w; k++) begin
        int c;
        c = m.rr ? (n.last + k) % m.w : k - 1;
        if (!n.valid && n.pend[c] && msk[c]) begin
          n.valid = 1'b1;
          n.idx = c;
        end
      end
    end
    for (int i = 0; i < m.w; i++)
      if (req[i]) n.pend[i] = 1'b1;
    return n;
  endfunction

  function automatic logic [31:0] onehot_of(input model_t m);
    return m.valid ? (32'd1 << m.idx) : 32'd0;
  endfunction

  task automatic compare_all();
    check("fix.valid",   32'(if_fix.out_valid),  32'(mf.valid));
    check("fix.idx",     32'(if_fix.out_idx),    32'(mf.idx));
    check("fix.onehot",  32'(if_fix.out_onehot), onehot_of(mf));
    check("fix.pending", 32'(if_fix.pending),    32'(mf.pend));
    check("fix.any",     32'(if_fix.any),        32'(|mf.pend));
    check("rr.valid",    32'(if_rr.out_valid),   32'(mr.valid));
    check("rr.idx",      32'(if_rr.out_idx),     32'(mr.idx));
    check("rr.onehot",   32'(if_rr.out_onehot),  onehot_of(mr));
    check("rr.pending",  32'(if_rr.pending),     32'(mr.pend));
    check("rr.any",      32'(if_rr.any),         32'(|mr.pend));
  endtask

  // One clock: both DUTs and models see the currently driven inputs.
  task automatic tick();
    @(posedge clk);
    mf = step(mf, 16'(req_f), rdy_f, 16'(mask_f));
    mr = step(mr, 16'(req_r), rdy_r, 16'h001F);
    #1;
    compare_all();
  endtask

  task automatic drain();
    req_f = '0; req_r = '0; rdy_f = 1'b1; rdy_r = 1'b1; mask_f = '1;
    repeat (20) tick();
    rdy_f = 1'b0; rdy_r = 1'b0;
  endtask

  initial begin
    int exp_a[5];
    mf = model_reset(WF, 1'b0);
    mr = model_reset(WR, 1'b1);

    // Reset state
    #12;
    compare_all();
    check("rst.fix.valid", 32'(if_fix.out_valid), 32'd0);
    rst_n = 1'b1;

    // Round-robin sweep from reset: 0,1,2,3,4
    req_r = 5'h1F; rdy_r = 1'b1;
    tick();
    req_r = '0;
    exp_a = '{0, 1, 2, 3, 4};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr.sweep.valid", 32'(if_rr.out_valid), 32'd1);
      check("rr.sweep.idx", 32'(if_rr.out_idx), 32'(exp_a[i]));
    end
    tick();
    check("rr.sweep.empty", 32'(if_rr.out_valid), 32'd0);
    // Serve 0,1,2 then re-pulse all: order resumes 3,4,0,1,2
    req_r = 5'h07;
    tick();
    req_r = '0;
    repeat (4) tick();
    req_r = 5'h1F;
    tick();
    req_r = '0;
    exp_a = '{3, 4, 0, 1, 2};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr.resume.idx", 32'(if_rr.out_idx), 32'(exp_a[i]));
    end
    tick();
    check("rr.resume.empty", 32'(if_rr.out_valid), 32'd0);
    rdy_r = 1'b0;

    // Fixed-priority latency and stall
    req_f = 16'h8010; rdy_f = 1'b0;
    tick();
    req_f = '0;
    check("lat.pending", 32'(if_fix.pending), 32'h8010);
    check("lat.valid0", 32'(if_fix.out_valid), 32'd0);
    tick();
    check("lat.idx", 32'(if_fix.out_idx), 32'd4);
    repeat (5) begin
      tick();
      check("lat.hold", 32'(if_fix.out_idx), 32'd4);
    end
    rdy_f = 1'b1;
    tick();
    check("lat.next", 32'(if_fix.out_idx), 32'd15);
    tick();
    check("lat.empty", 32'(if_fix.out_valid), 32'd0);
    check("lat.clear", 32'(if_fix.pending), 32'd0);
    rdy_f = 1'b0;

    // Set/clear collision on index 3
    req_f = 16'h0008;
    tick();
    req_f = '0;
    tick();
    check("col.idx", 32'(if_fix.out_idx), 32'd3);
    req_f = 16'h0008; rdy_f = 1'b1;
    tick();
    req_f = '0;
    check("col.kept", 32'(if_fix.pending[3]), 32'd1);
    tick();
    check("col.again", 32'(if_fix.out_idx), 32'd3);
    check("col.again.v", 32'(if_fix.out_valid), 32'd1);
    tick();
    rdy_f = 1'b0;

    // Stall stability: 6 held while a higher-priority event arrives
    req_f = 16'h0040;
    tick();
    req_f = '0;
    tick();
    req_f = 16'h0001;
    tick();
    req_f = '0;
    repeat (2) begin
      tick();
      check("stall.hold", 32'(if_fix.out_idx), 32'd6);
    end
    rdy_f = 1'b1;
    tick();
    check("stall.next", 32'(if_fix.out_idx), 32'd0);
    tick();
    rdy_f = 1'b0;

`ifdef PENDING_ENCODER_MASK_EN
    // Mask: bit 0 pending but ineligible
    req_f = 16'h0003; rdy_f = 1'b1; mask_f = 16'hFFFE;
    tick();
    req_f = '0;
    tick();
    check("mask.idx", 32'(if_fix.out_idx), 32'd1);
    tick();
    check("mask.empty", 32'(if_fix.out_valid), 32'd0);
    check("mask.any", 32'(if_fix.any), 32'd1);
    mask_f = 16'hFFFF;
    tick();
    check("mask.open", 32'(if_fix.out_idx), 32'd0);
    check("mask.open.v", 32'(if_fix.out_valid), 32'd1);
    drain();
`endif

    // Async reset mid-stall
    req_f = 16'h0100; req_r = 5'h06;
    tick();
    req_f = '0; req_r = '0;
    tick();
    check("ars.pre", 32'(if_fix.out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    mf = model_reset(WF, 1'b0);
    mr = model_reset(WR, 1'b1);
    check("ars.fix.valid", 32'(if_fix.out_valid), 32'd0);
    check("ars.fix.pending", 32'(if_fix.pending), 32'd0);
    check("ars.rr.valid", 32'(if_rr.out_valid), 32'd0);
    compare_all();
    #2;
    rst_n = 1'b1;
    req_r = 5'h1F; rdy_r = 1'b1;
    tick();
    req_r = '0;
    tick();
    check("ars.rr.first", 32'(if_rr.out_idx), 32'd0);
    drain();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      req_f = 16'($urandom & $urandom & $urandom);
      req_r = 5'($urandom & $urandom);
      rdy_f = ($urandom_range(0, 3) != 0);
      rdy_r = ($urandom_range(0, 3) != 0);
`ifdef PENDING_ENCODER_MASK_EN
      if ($urandom_range(0, 7) == 0) mask_f = 16'($urandom | $urandom);
`endif
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pending_encoder.md
# pending_encoder

- Registered, handshaked successor to the combinational one-hot decoder.
- Latches event pulses from `INPUT_WIDTH` sources into a pending vector and emits one encoded index per accepted transfer.
- Clears each served bit on handshake.
- Selects by fixed lowest-index priority or round-robin.
- Sits between interrupt/exception/event sources and the consumer that services them (CP0 interrupt logic, arbiters).

## Interface
Parameters:
- `INPUT_WIDTH`, 16, number of event sources; ≥2, need not be a power of two.
- `OUTPUT_WIDTH`, clogb2(INPUT_WIDTH-1), width of encoded index.
- `ROUND_ROBIN`, 0, 0 = fixed priority (lowest index wins), 1 = rotating priority.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in INPUT_WIDTH: event pulses; each high bit sets its pending bit.
- `out_ready` in 1: consumer accepts `out_idx` this cycle.
- `out_valid` out 1: `out_idx`/`out_onehot` hold a pending event.
- `out_idx` out OUTPUT_WIDTH: encoded index of selected event.
- `out_onehot` out INPUT_WIDTH: one-hot form of `out_idx`; zero when `out_valid`=0.
- `pending` out INPUT_WIDTH: pending register P.
- `any` out 1: registered |P.
- `mask` in INPUT_WIDTH: present only with `PENDING_ENCODER_MASK_EN`; 1 = eligible.

## Operation
- Handshake hs = `out_valid` & `out_ready`; hs_onehot = hs ? `out_onehot` : 0.
- Pending update: P_next = (P & ~hs_onehot) | `req`. If set and clear hit the same bit in one cycle, the set wins; the event is retained and served again later.
- Candidate set C = P & ~hs_onehot (& `mask` when enabled). `req` of the current cycle is not in C.
- Output register loads when `out_valid`=0 or hs:
  - `out_valid` <= |C.
  - `out_idx` / `out_onehot` <= selection from C, or 0 if C empty.
- When `out_valid`=1 and `out_ready`=0, all outputs hold unchanged. New higher-priority events and mask changes do not alter a presented index.
- Fixed priority: lowest set index of C.
- Round-robin:
  - Pointer `ptr` holds the last served index and updates to `out_idx` on hs only.
  - Search starts at `ptr`+1, ascending, wrapping from INPUT_WIDTH-1 to 0, so `ptr` itself has lowest priority.
- Index arithmetic is modulo INPUT_WIDTH, not 2^OUTPUT_WIDTH. Non-power-of-two widths must never emit an index ≥ INPUT_WIDTH.
- `any` <= |P_next (unmasked).

## Timing
- Reset (async, any time, including mid-stall):
  - P = 0, `out_valid` = 0, `out_idx` = 0, `out_onehot` = 0, `any` = 0.
  - `ptr` = INPUT_WIDTH-1, so the first round-robin search starts at 0.
  - `out_ready` is ignored during reset.
- Latency: `req` bit high before edge N sets P at N; `out_valid` rises at edge N+1 (2 cycles req→valid). `pending`/`any` reflect it after edge N.
- Throughput: one event per cycle with `out_ready` held high. A served bit never reappears in the next selection unless re-requested.
- All events pending, `out_ready`=1, ROUND_ROBIN=1: grants sweep 0,1,…,INPUT_WIDTH-1,0 with no repeats or skips.
- Empty: C empty at a load edge → `out_valid`=0, `out_onehot`=0.
- Stall: an index presented with `out_ready`=0 stays until accepted. Its P bit stays set until that edge.

## Configuration
- `PENDING_ENCODER_MASK_EN` defined:
  - Adds the `mask` port; only P & `mask` bits are selectable.
  - Masked bits stay pending and still count in `any`/`pending`.
  - A mask change affects only the next load, never a held output.
- Undefined: no `mask` port; behaviour identical to `mask` all ones.

## Test plan
- Reset/latency: W=16, fixed. Pulse `req`=0x0000_8010 for one cycle, `out_ready`=0 → `pending`=0x8010 after 1 edge, `out_valid`=1/`out_idx`=4 after 2 edges, held 5 stalled cycles. Raise `out_ready` → next `out_idx`=15, then `out_valid`=0, `pending`=0.
- Round-robin sweep: W=5, ROUND_ROBIN=1, `req`=0x1F once, `out_ready`=1 → indices 0,1,2,3,4 on consecutive cycles. Re-pulse 0x1F after serving 2 → order continues 3,4,0,1,2 with no index ≥5.
- Set/clear collision: handshake on idx 3 while `req`[3]=1 → `pending`[3] stays 1, idx 3 re-presented later.
- Stall stability: `out_idx`=6 stalled, then `req`[0] pulses → `out_idx` stays 6 until accepted, then 0.
- Async reset mid-stall: `rst_n` low between edges with `out_valid`=1 → all outputs 0 immediately. After release, round-robin starts at index 0.
- Mask (`PENDING_ENCODER_MASK_EN`): `pending`=0x0003, `mask`=0xFFFE → `out_idx`=1 only. After serve, `out_valid`=0, `any`=1. Set `mask`[0]=1 → `out_idx`=0 next cycle.
